control_pa200: RTL and testbench
================================

Name: control_pa200

Overview:
Sequencer for the 200 Hz second-order high-pass filter datapath, i.e. the controlling end of that datapath's select/enable interface. On each input sample tick it drives the three mux selects and the seven register enables through a fixed six-step micro-program:
- fk = uk − a1·fk1 − a2·fk2
- yk = b0·fk + b1·fk1 + b2·fk2, with b2 = b0

It reports busy, done and sample overrun to the sample-rate logic.

Parameters:
STEP_CYC, 1, clock cycles per micro-step (≥1). Allows multi-cycle multiplier settling.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
sample_tick  input  1  one-cycle pulse: new uk valid, start computation
clr_ovr  input  1  synchronous clear of the overrun flag
en1..en7  output  1 each  register enables: yk, fk, fk1, fk2, acum1, acum2, acum3
selmuxS  output  3  multiplicand select: 0=uk, 1=fk, 2=fk1, 3=fk2, 4=yk
selmuxC  output  2  coefficient select: 0=−a1, 1=−a2, 2=b0(=b2), 3=b1
selmuxZ  output  3  addend select: 0=zero, 1=uk, 2=acum1, 3=acum2, 4=acum3
busy  output  1  high in steps T1..T6
done  output  1  one-cycle pulse; yk register holds the new result
overrun  output  1  sticky: a tick arrived while busy
step  output  3  current state code (debug): IDLE=0, T1..T6=1..6, DONE=7

Behaviour:
- Moore FSM: IDLE → T1 → … → T6 → DONE → IDLE. Outputs are decoded from state only.
- Step counter 0..STEP_CYC−1 within each Tn. The state advances when the counter reaches STEP_CYC−1.
- Selects hold constant for the whole step. Enables assert only in the step's last cycle, so each register loads exactly once per step.
- Micro-program (S, C, Z, enables). Selects not listed are 0.
  - T1: en3, en4 only. fk1←fk and fk2←fk1 on the same edge, giving fk1=f(k−1), fk2=f(k−2).
  - T2: S=2, C=0, Z=1, en5. acum1 = −a1·fk1 + uk.
  - T3: S=3, C=1, Z=2, en2. fk = −a2·fk2 + acum1.
  - T4: S=1, C=2, Z=0, en6. acum2 = b0·fk.
  - T5: S=2, C=3, Z=3, en7. acum3 = b1·fk1 + acum2.
  - T6: S=3, C=2, Z=4, en1. yk = b0·fk2 + acum3.
- IDLE and DONE: all enables 0, all selects 0.
- busy = 1 in T1..T6. done = 1 only in DONE.
- Latency: tick sampled at edge n → T1 starts cycle n+1 → DONE at cycle n+6·STEP_CYC+1. With STEP_CYC=1, done is 7 cycles after the tick.
- Tick acceptance:
  - A tick is accepted in IDLE or DONE. In DONE the FSM goes to T1 next cycle (back-to-back), no IDLE gap.
  - A tick in T1..T6 is ignored and sets overrun; the current computation continues unaffected.
- uk must be stable from the tick through the end of T2. This is a requirement on the upstream logic, not checked by this block.
- overrun:
  - Set has priority over clr_ovr in the same cycle.
  - Held until clr_ovr or reset.
- reset = 0 at a clock edge:
  - State → IDLE, counter → 0, overrun → 0.
  - All enables, selects, busy and done are 0 from that edge on.
  - A computation in progress is abandoned; no further enables issue.
- Ticks are ignored while reset is low.
- step codes outside those listed are unreachable. If reached, the FSM returns to IDLE on the next edge with all enables 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with sample_tick toggling → all enables/selects/busy/done/overrun = 0, step=0.
- Single sample, STEP_CYC=1, tick at cycle 10:
  - en3/en4 at cycle 11, en5 at 12, en2 at 13, en6 at 14, en7 at 15, en1 at 16; selects match the table each cycle.
  - done=1 only at cycle 17.
  - Datapath model with uk=1000, a1=a2=0, b0=1, b1=−2 gives yk=1000.
- STEP_CYC=3:
  - Each step's selects held 3 cycles; its enable is high only in the 3rd cycle.
  - Tick at cycle 0 → done at cycle 19.
- Back-to-back and overrun (STEP_CYC=1):
  - Tick in DONE cycle → T1 next cycle, overrun stays 0.
  - Tick during T4 → ignored, overrun=1 from the next cycle, done still at the original time.
  - clr_ovr clears it; clr_ovr together with a new overrun tick leaves overrun=1.
- Reset mid-operation: reset=0 during T3 → next cycle step=0 and en1..en7 = 0; the yk register is never loaded. A tick after release gives normal timing.

Source files
------------

// File: rtl/control_pa200.sv
// Sequencer for the 200 Hz second-order high-pass filter datapath.
// Each accepted sample tick runs a six-step micro-program over the mux selects and register enables.
module control_pa200 #(
    parameter int STEP_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       clr_ovr,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [2:0] step
);

    // Handshake: sample_tick is a one-cycle pulse with no back-pressure. It is
    // accepted only in IDLE or DONE; busy acts as not-ready, and a tick that
    // arrives while busy is dropped and recorded in the sticky overrun flag.

    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_T6   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          in_step;
    logic          last;

    assign in_step = (state >= S_T1) && (state <= S_T6);
    assign last    = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = sample_tick ? S_T1 : S_IDLE;
            end
            S_T1, S_T2, S_T3, S_T4, S_T5, S_T6: begin
                if (last) begin
                    // T6 + 1 wraps naturally onto the DONE code.
                    cnt_nxt   = '0;
                    state_nxt = state + 3'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (sample_tick && in_step) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Selects follow the step; each enable fires only on the step's final cycle.
    always_comb begin
        en1     = 1'b0;
        en2     = 1'b0;
        en3     = 1'b0;
        en4     = 1'b0;
        en5     = 1'b0;
        en6     = 1'b0;
        en7     = 1'b0;
        selmuxS = 3'd0;
        selmuxC = 2'd0;
        selmuxZ = 3'd0;
        case (state)
            S_T1: begin
                en3 = last;
                en4 = last;
            end
            S_T2: begin
                selmuxS = 3'd2;
                selmuxC = 2'd0;
                selmuxZ = 3'd1;
                en5     = last;
            end
            S_T3: begin
                selmuxS = 3'd3;
                selmuxC = 2'd1;
                selmuxZ = 3'd2;
                en2     = last;
            end
            S_T4: begin
                selmuxS = 3'd1;
                selmuxC = 2'd2;
                selmuxZ = 3'd0;
                en6     = last;
            end
            S_T5: begin
                selmuxS = 3'd2;
                selmuxC = 2'd3;
                selmuxZ = 3'd3;
                en7     = last;
            end
            S_T6: begin
                selmuxS = 3'd3;
                selmuxC = 2'd2;
                selmuxZ = 3'd4;
                en1     = last;
            end
            default: begin
                en1 = 1'b0;
            end
        endcase
    end

    assign busy = in_step;
    assign done = (state == S_DONE);
    assign step = state;

endmodule

// File: tb/tb_control_pa200.sv
// Bench for control_pa200: two instances (STEP_CYC=1 and 3) checked against a
// schedule model driven by elapsed cycles, plus a behavioural datapath for yk.
module tb_control_pa200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic tick_a = 1'b0;
    logic tick_b = 1'b0;
    logic clr = 1'b0;

    logic [7:1] en_a, en_b;
    logic [2:0] s_a, z_a, step_a, s_b, z_b, step_b;
    logic [1:0] c_a, c_b;
    logic       busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

    control_pa200 #(.STEP_CYC(1)) dut_a (
        .clk(clk), .reset(rst_n), .sample_tick(tick_a), .clr_ovr(clr),
        .en1(en_a[1]), .en2(en_a[2]), .en3(en_a[3]), .en4(en_a[4]),
        .en5(en_a[5]), .en6(en_a[6]), .en7(en_a[7]),
        .selmuxS(s_a), .selmuxC(c_a), .selmuxZ(z_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a), .step(step_a)
    );

    control_pa200 #(.STEP_CYC(3)) dut_b (
        .clk(clk), .reset(rst_n), .sample_tick(tick_b), .clr_ovr(clr),
        .en1(en_b[1]), .en2(en_b[2]), .en3(en_b[3]), .en4(en_b[4]),
        .en5(en_b[5]), .en6(en_b[6]), .en7(en_b[7]),
        .selmuxS(s_b), .selmuxC(c_b), .selmuxZ(z_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b), .step(step_b)
    );

    logic [20:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {en_a, s_a, c_a, z_a, busy_a, done_a, ovr_a, step_a};
    assign obs_b = {en_b, s_b, c_b, z_b, busy_b, done_b, ovr_b, step_b};

    int checks = 0;
    int errors = 0;

    // Reference model: a computation is "active" and e counts edges since the
    // accepting edge (e=1 is the first step cycle).
    bit act[2];
    int e[2];
    bit movr[2];
    int sc[2] = '{1, 3};

    function automatic void model_edge(input int i, input bit r, input bit tk, input bit cl);
        bit busy_now;
        busy_now = act[i] && (e[i] >= 1) && (e[i] <= 6 * sc[i]);
        if (!r) begin
            act[i]  = 1'b0;
            e[i]    = 0;
            movr[i] = 1'b0;
        end else begin
            if (tk && busy_now) movr[i] = 1'b1;
            else if (cl) movr[i] = 1'b0;
            if (tk && !busy_now) begin
                act[i] = 1'b1;
                e[i]   = 1;
            end else if (act[i]) begin
                e[i] = e[i] + 1;
                if (e[i] > 6 * sc[i] + 1) begin
                    act[i] = 1'b0;
                    e[i]   = 0;
                end
            end
        end
    endfunction

    function automatic logic [20:0] exp_vec(input int s, input bit a, input int ee, input bit o);
        logic [7:1] en;
        logic [2:0] ss, zz, st;
        logic [1:0] cc;
        logic       bz, dn;
        int         k;
        bit         lst;
        en = '0; ss = 3'd0; zz = 3'd0; cc = 2'd0; st = 3'd0; k = 0; lst = 1'b0;
        if (a && ee >= 1 && ee <= 6 * s) begin
            k   = (ee - 1) / s + 1;
            lst = ((ee % s) == 0);
            st  = 3'(k);
            case (k)
                1: begin en[3] = lst; en[4] = lst; end
                2: begin ss = 3'd2; cc = 2'd0; zz = 3'd1; en[5] = lst; end
                3: begin ss = 3'd3; cc = 2'd1; zz = 3'd2; en[2] = lst; end
                4: begin ss = 3'd1; cc = 2'd2; zz = 3'd0; en[6] = lst; end
                5: begin ss = 3'd2; cc = 2'd3; zz = 3'd3; en[7] = lst; end
                default: begin ss = 3'd3; cc = 2'd2; zz = 3'd4; en[1] = lst; end
            endcase
        end else if (a && ee == 6 * s + 1) begin
            st = 3'd7;
        end
        bz = (k >= 1);
        dn = (st == 3'd7);
        return {en, ss, cc, zz, bz, dn, o, st};
    endfunction

    // Behavioural datapath driven by instance A's selects and enables.
    longint uk_in = 0, ca1 = 0, ca2 = 0, cb0 = 0, cb1 = 0;
    longint dp_yk = 0, dp_fk = 0, dp_fk1 = 0, dp_fk2 = 0;
    longint dp_ac1 = 0, dp_ac2 = 0, dp_ac3 = 0;
    logic   dp_clear = 1'b0;

    function automatic longint mux_s(input logic [2:0] s);
        case (s)
            3'd0: return uk_in;
            3'd1: return dp_fk;
            3'd2: return dp_fk1;
            3'd3: return dp_fk2;
            3'd4: return dp_yk;
            default: return 0;
        endcase
    endfunction

    function automatic longint mux_c(input logic [1:0] c);
        case (c)
            2'd0: return -ca1;
            2'd1: return -ca2;
            2'd2: return cb0;
            default: return cb1;
        endcase
    endfunction

    function automatic longint mux_z(input logic [2:0] z);
        case (z)
            3'd1: return uk_in;
            3'd2: return dp_ac1;
            3'd3: return dp_ac2;
            3'd4: return dp_ac3;
            default: return 0;
        endcase
    endfunction

    function automatic longint dp_sum();
        return mux_s(s_a) * mux_c(c_a) + mux_z(z_a);
    endfunction

    always @(posedge clk) begin
        if (dp_clear) begin
            dp_yk <= 0; dp_fk <= 0; dp_fk1 <= 0; dp_fk2 <= 0;
            dp_ac1 <= 0; dp_ac2 <= 0; dp_ac3 <= 0;
        end else begin
            if (en_a[1]) dp_yk  <= dp_sum();
            if (en_a[2]) dp_fk  <= dp_sum();
            if (en_a[3]) dp_fk1 <= dp_fk;
            if (en_a[4]) dp_fk2 <= dp_fk1;
            if (en_a[5]) dp_ac1 <= dp_sum();
            if (en_a[6]) dp_ac2 <= dp_sum();
            if (en_a[7]) dp_ac3 <= dp_sum();
        end
    end

    // One clock: drive at negedge, model the edge, settle, publish expectations.
    task automatic step_cycle(input bit r, input bit ta, input bit tb_, input bit c);
        @(negedge clk);
        rst_n  = r;
        tick_a = ta;
        tick_b = tb_;
        clr    = c;
        @(posedge clk);
        model_edge(0, r, ta, c);
        model_edge(1, r, tb_, c);
        #1;
        exp_a = exp_vec(sc[0], act[0], e[0], movr[0]);
        exp_b = exp_vec(sc[1], act[1], e[1], movr[1]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step_cycle(1'b0, i[0], ~i[0], 1'b0);
            checks++;
            if (obs_a !== 21'd0) begin
                errors++;
                $display("FAIL reset_a_zero got %h want %h", obs_a, 21'd0);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL reset_b got %h want %h", obs_b, exp_b);
            end
        end
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        int lat;
        lat = -1;
        step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL single_cyc%0d got %h want %h", i, obs_a, exp_a);
            end
            if (i == 1) begin
                checks++;
                if (en_a !== 7'b0001100) begin
                    errors++;
                    $display("FAIL single_t1_en got %b want %b", en_a, 7'b0001100);
                end
            end
            if (i == 6) begin
                checks++;
                if (en_a !== 7'b0000001) begin
                    errors++;
                    $display("FAIL single_t6_en got %b want %b", en_a, 7'b0000001);
                end
            end
            if (done_a === 1'b1 && lat < 0) lat = i;
            step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL single_latency got %0d want %0d", lat, 7);
        end
    endtask

    task automatic test_step3();
        int lat;
        int en_cnt;
        lat = -1;
        en_cnt = 0;
        step_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 22; i++) begin
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL step3_cyc%0d got %h want %h", i, obs_b, exp_b);
            end
            if (done_b === 1'b1 && lat < 0) lat = i;
            if (|en_b) en_cnt++;
            step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (lat != 19) begin
            errors++;
            $display("FAIL step3_latency got %0d want %0d", lat, 19);
        end
        checks++;
        if (en_cnt != 6) begin
            errors++;
            $display("FAIL step3_enable_cycles got %0d want %0d", en_cnt, 6);
        end
    endtask

    task automatic test_datapath();
        longint fr1, fr2, f, y;
        fr1 = 0;
        fr2 = 0;
        dp_clear = 1'b1;
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        dp_clear = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                uk_in = 1000; ca1 = 0; ca2 = 0; cb0 = 1; cb1 = -2;
            end else begin
                uk_in = longint'($urandom_range(200, 0)) - 100;
                ca1   = longint'($urandom_range(6, 0)) - 3;
                ca2   = longint'($urandom_range(6, 0)) - 3;
                cb0   = longint'($urandom_range(6, 0)) - 3;
                cb1   = longint'($urandom_range(6, 0)) - 3;
            end
            f   = uk_in - ca1 * fr1 - ca2 * fr2;
            y   = cb0 * f + cb1 * fr1 + cb0 * fr2;
            fr2 = fr1;
            fr1 = f;
            step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 1; i <= 7; i++) begin
                checks++;
                if (obs_a !== exp_a) begin
                    errors++;
                    $display("FAIL dp_seq s%0d c%0d got %h want %h", n, i, obs_a, exp_a);
                end
                if (i < 7) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end
            checks++;
            if (dp_yk != y) begin
                errors++;
                $display("FAIL dp_yk s%0d got %0d want %0d", n, dp_yk, y);
            end
            if (n == 0) begin
                checks++;
                if (dp_yk != 1000) begin
                    errors++;
                    $display("FAIL dp_yk_1000 got %0d want %0d", dp_yk, 1000);
                end
            end
            step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        bit tk_seq[25] = '{1,0,0,0,0,0,0,1,0,0,0,1,0,0,0,1,1,0,0,0,0,0,0,0,0};
        bit cl_seq[25] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0,0,0,0,0,0,1,0};
        for (int i = 0; i < 25; i++) begin
            step_cycle(1'b1, tk_seq[i], 1'b0, cl_seq[i]);
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL b2b_cyc%0d got %h want %h", i, obs_a, exp_a);
            end
            if (i == 7) begin
                checks++;
                if (step_a !== 3'd1 || ovr_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_done_tick got step %0d ovr %b want step 1 ovr 0", step_a, ovr_a);
                end
            end
            if (i == 11 || i == 16) begin
                checks++;
                if (ovr_a !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_set_%0d got %b want %b", i, ovr_a, 1'b1);
                end
            end
            if (i == 13) begin
                checks++;
                if (done_a !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_done_time got %b want %b", done_a, 1'b1);
                end
            end
            if (i == 14) begin
                checks++;
                if (ovr_a !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_clear got %b want %b", ovr_a, 1'b0);
                end
            end
        end
    endtask

    task automatic test_random();
        bit r, ta, tb_, c;
        for (int i = 0; i < 300; i++) begin
            r   = ($urandom_range(63, 0) != 0);
            ta  = ($urandom_range(3, 0) == 0);
            tb_ = ($urandom_range(5, 0) == 0);
            c   = ($urandom_range(7, 0) == 0);
            step_cycle(r, ta, tb_, c);
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL rand_a cyc%0d got %h want %h", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL rand_b cyc%0d got %h want %h", i, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        longint yk_hold;
        int     lat;
        bit     en1_seen;
        en1_seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 25; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (step_a !== 3'd3) begin
            errors++;
            $display("FAIL rmid_in_t3 got %0d want %0d", step_a, 3);
        end
        yk_hold = dp_yk;
        step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (step_a !== 3'd0 || en_a !== 7'd0 || step_b !== 3'd0 || en_b !== 7'd0) begin
            errors++;
            $display("FAIL rmid_abort got step %0d/%0d en %b/%b want 0", step_a, step_b, en_a, en_b);
        end
        for (int i = 0; i < 8; i++) begin
            step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (en_a[1] === 1'b1) en1_seen = 1'b1;
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL rmid_idle cyc%0d got %h want %h", i, obs_a, exp_a);
            end
        end
        checks++;
        if (en1_seen || dp_yk != yk_hold) begin
            errors++;
            $display("FAIL rmid_yk got %0d en1 %b want %0d en1 0", dp_yk, en1_seen, yk_hold);
        end
        step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            if (done_a === 1'b1 && lat < 0) lat = i;
            step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL rmid_restart_latency got %0d want %0d", lat, 7);
        end
    endtask

    initial begin
        act  = '{1'b0, 1'b0};
        e    = '{0, 0};
        movr = '{1'b0, 1'b0};
        test_reset();
        test_single();
        test_step3();
        test_datapath();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
